debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_chan.sv | 102 ++++++++++
 rtl/debounce_bank.sv | 37 +++
 tb/tb_debounce_bank.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the debounce bank.
// Keeps the parameter defaults and counter sizing in one place for the top and the channel.
package debounce_pkg;

    localparam int DEF_CHANNELS      = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES   = 50000000;

    // Bits needed to hold the value n, i.e. ceil(log2(n+1)), never less than 1.
    function automatic int cnt_width(input int n);
        int     w = 1;
        longint v = 2;
        while (v <= longint'(n)) begin
            w++;
            v = v * 2;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: input synchroniser, stability counter, edge pulses and
// an optional long-press (hold) detector.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_out,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold
);

    localparam int            SW          = cnt_width(STABLE_CYCLES);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SW-1:0]          r_cnt;
    logic                   r_out;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync;
    logic                   w_accept;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_accept = (w_sync != r_out) && (r_cnt == STABLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
        end
    end

    // Any return to the current level throws the partial count away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_out  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept & w_sync;
            r_fall <= w_accept & ~w_sync;
            if (w_sync == r_out) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= '0;
                r_out <= w_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_out  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

    generate
        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int            HW        = cnt_width(HOLD_CYCLES);
            localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
            localparam logic [HW-1:0] HOLD_DONE = HW'(HOLD_CYCLES);

            logic [HW-1:0] r_hcnt;
            logic          r_hold;
            logic          w_fall_now;

            // A fall accepted on the firing edge wins, so hold never coincides with fall.
            assign w_fall_now = w_accept & r_out;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hcnt <= '0;
                    r_hold <= 1'b0;
                end else begin
                    r_hold <= 1'b0;
                    if (!r_out || w_fall_now) begin
                        r_hcnt <= '0;
                    end else if (r_hcnt == HOLD_LAST) begin
                        r_hcnt <= HOLD_DONE;
                        r_hold <= 1'b1;
                    end else if (r_hcnt != HOLD_DONE) begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
            end

            assign o_hold = r_hold;
        end else begin : g_no_hold
            assign o_hold = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels; pure instantiation and bit-slicing.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            debounce_chan #(
                .SYNC_STAGES   (SYNC_STAGES),
                .STABLE_CYCLES (STABLE_CYCLES),
                .HOLD_CYCLES   (HOLD_CYCLES)
            ) u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_in   (in[i]),
                .o_out  (out[i]),
                .o_rise (rise[i]),
                .o_fall (fall[i]),
                .o_hold (hold[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with short timing parameters (2 sync, 8 stable, 20 hold).
// Event cycles are counted in clock edges after the input is first presented.
module tb_debounce_bank;

    localparam int CH = 4;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] in_r;
    logic [CH-1:0] out_w;
    logic [CH-1:0] rise_w;
    logic [CH-1:0] fall_w;
    logic [CH-1:0] hold_w;

    int n_tot;
    int n_bad;

    debounce_bank #(
        .CHANNELS      (CH),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_r),
        .out   (out_w),
        .rise  (rise_w),
        .fall  (fall_w),
        .hold  (hold_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] vec();
        return {hold_w, fall_w, rise_w, out_w};
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] o, input logic [3:0] r,
                                       input logic [3:0] f, input logic [3:0] h);
        return {h, f, r, o};
    endfunction

    initial begin
        n_tot = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_r  = 4'b1111;

        // Reset holds everything at zero even with inputs high.
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("reset_%0d", k), vec(), 16'h0000);
        end
        in_r = 4'b0000;
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("idle_%0d", k), vec(), 16'h0000);
        end

        // Single clean press on channel 0: out at edge 10, release seen at edge 22.
        for (int k = 1; k <= 25; k++) begin
            in_r = (k <= 12) ? 4'b0001 : 4'b0000;
            cyc();
            chk($sformatf("ch0_press_%0d", k), vec(),
                mk((k >= 10 && k <= 21) ? 4'b0001 : 4'b0000,
                   (k == 10) ? 4'b0001 : 4'b0000,
                   (k == 22) ? 4'b0001 : 4'b0000,
                   4'b0000));
        end

        // Bouncing channel 1 never stays stable long enough.
        for (int k = 0; k < 42; k++) begin
            in_r = (k < 30 && ((k / 3) % 2 == 0)) ? 4'b0010 : 4'b0000;
            cyc();
            chk($sformatf("ch1_bounce_%0d", k), vec(), 16'h0000);
        end

        // Channel 2: 7 cycles high is rejected.
        for (int k = 1; k <= 20; k++) begin
            in_r = (k <= 7) ? 4'b0100 : 4'b0000;
            cyc();
            chk($sformatf("ch2_short7_%0d", k), vec(), 16'h0000);
        end

        // Channel 2: 8 cycles high is accepted, rise at 10, fall at 18.
        for (int k = 1; k <= 22; k++) begin
            in_r = (k <= 8) ? 4'b0100 : 4'b0000;
            cyc();
            chk($sformatf("ch2_pulse8_%0d", k), vec(),
                mk((k >= 10 && k <= 17) ? 4'b0100 : 4'b0000,
                   (k == 10) ? 4'b0100 : 4'b0000,
                   (k == 18) ? 4'b0100 : 4'b0000,
                   4'b0000));
        end

        // Channel 3 long press: rise 10, hold 30, fall 50, nothing after.
        for (int k = 1; k <= 60; k++) begin
            in_r = (k <= 40) ? 4'b1000 : 4'b0000;
            cyc();
            chk($sformatf("ch3_hold_%0d", k), vec(),
                mk((k >= 10 && k <= 49) ? 4'b1000 : 4'b0000,
                   (k == 10) ? 4'b1000 : 4'b0000,
                   (k == 50) ? 4'b1000 : 4'b0000,
                   (k == 30) ? 4'b1000 : 4'b0000));
        end

        // All channels together respond on the same edges.
        for (int k = 1; k <= 25; k++) begin
            in_r = (k <= 12) ? 4'b1111 : 4'b0000;
            cyc();
            chk($sformatf("all_%0d", k), vec(),
                mk((k >= 10 && k <= 21) ? 4'b1111 : 4'b0000,
                   (k == 10) ? 4'b1111 : 4'b0000,
                   (k == 22) ? 4'b1111 : 4'b0000,
                   4'b0000));
        end

        // Reset in the middle of a count, input kept high throughout.
        in_r = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("pre_rst_%0d", k), vec(), 16'h0000);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_async", vec(), 16'h0000);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("in_rst_%0d", k), vec(), 16'h0000);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("post_rst_%0d", k), vec(),
                mk((k >= 10) ? 4'b0001 : 4'b0000,
                   (k == 10) ? 4'b0001 : 4'b0000,
                   4'b0000, 4'b0000));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
